// File: rtl/sp_ram_arbiter_if.sv
// Bundle of master-side req/gnt/rvalid ports and the shared single-port RAM port.
// The arbiter uses the slave modport; the requesters/RAM environment uses master.
interface sp_ram_arbiter_if #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32
);
  logic [NUM_MASTERS-1:0]            m_req_i;
  logic [NUM_MASTERS-1:0]            m_gnt_o;
  logic [NUM_MASTERS-1:0]            m_rvalid_o;
  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr_i;
  logic [NUM_MASTERS-1:0]            m_we_i;
  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata_i;
  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_rdata_o;
  logic                              mem_req_o;
  logic                              mem_gnt_i;
  logic                              mem_rvalid_i;
  logic [ADDR_WIDTH-1:0]             mem_addr_o;
  logic                              mem_we_o;
  logic [DATA_WIDTH-1:0]             mem_wdata_o;
  logic [DATA_WIDTH-1:0]             mem_rdata_i;

  modport slave (
    input  m_req_i, m_addr_i, m_we_i, m_wdata_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output m_gnt_o, m_rvalid_o, m_rdata_o, mem_req_o, mem_addr_o, mem_we_o, mem_wdata_o
  );

  modport master (
    output m_req_i, m_addr_i, m_we_i, m_wdata_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  m_gnt_o, m_rvalid_o, m_rdata_o, mem_req_o, mem_addr_o, mem_we_o, mem_wdata_o
  );
endinterface

// File: rtl/sp_ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between NUM_MASTERS requesters.
// Read data is captured at grant time and returned to the owner one cycle later.
module sp_ram_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sp_ram_arbiter_if.slave      bus,
  output logic                 err_o,
  output logic [CNT_WIDTH-1:0] contention_cnt_o
);
  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  logic [IDX_W-1:0]      r_rr_ptr, r_resp_owner;
  logic                  r_resp_pending, r_rst_mask, r_err;
  logic [DATA_WIDTH-1:0] r_rdata_q;
  logic [CNT_WIDTH-1:0]  r_cnt;

  logic [IDX_W-1:0]      w_sel, w_ptr_nxt;
  logic                  w_found, w_any, w_hs, w_contend;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic                  w_we;

  // Two passes: indices at/after the pointer win, then wrap to those below it.
  always_comb begin
    w_sel   = '0;
    w_found = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (!w_found && bus.m_req_i[i] && (IDX_W'(i) >= r_rr_ptr)) begin
        w_found = 1'b1;
        w_sel   = IDX_W'(i);
      end
    end
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (!w_found && bus.m_req_i[i]) begin
        w_found = 1'b1;
        w_sel   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    w_addr  = '0;
    w_we    = 1'b0;
    w_wdata = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (w_any && (w_sel == IDX_W'(i))) begin
        w_addr  = bus.m_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_we    = bus.m_we_i[i];
        w_wdata = bus.m_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign w_any     = |bus.m_req_i;
  assign w_hs      = rst_n & w_any & bus.mem_gnt_i;
  assign w_contend = ($countones(bus.m_req_i) >= 2);
  assign w_ptr_nxt = (w_sel == IDX_W'(NUM_MASTERS-1)) ? '0 : w_sel + 1'b1;

  assign bus.mem_req_o   = rst_n & w_any;
  assign bus.mem_addr_o  = w_addr;
  assign bus.mem_we_o    = w_we;
  assign bus.mem_wdata_o = w_wdata;

  for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_port
    assign bus.m_gnt_o[g]    = w_hs & (w_sel == IDX_W'(g));
    assign bus.m_rvalid_o[g] = rst_n & bus.mem_rvalid_i & r_resp_pending &
                               (r_resp_owner == IDX_W'(g));
    assign bus.m_rdata_o[g*DATA_WIDTH +: DATA_WIDTH] =
      (r_resp_owner == IDX_W'(g)) ? r_rdata_q : '0;
  end

  // r_rst_mask hides a RAM rvalid left over from a handshake just before reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rr_ptr       <= '0;
      r_resp_owner   <= '0;
      r_resp_pending <= 1'b0;
      r_rdata_q      <= '0;
      r_err          <= 1'b0;
      r_cnt          <= '0;
      r_rst_mask     <= 1'b1;
    end else begin
      r_rst_mask <= 1'b0;
      if (w_hs) begin
        r_rr_ptr       <= w_ptr_nxt;
        r_resp_owner   <= w_sel;
        r_resp_pending <= 1'b1;
        r_rdata_q      <= bus.mem_rdata_i;
      end else begin
        r_resp_pending <= 1'b0;
      end
      if (bus.mem_rvalid_i && !r_resp_pending && !r_rst_mask)
        r_err <= 1'b1;
      if (w_contend && (r_cnt != {CNT_WIDTH{1'b1}}))
        r_cnt <= r_cnt + 1'b1;
    end
  end

  assign err_o            = r_err;
  assign contention_cnt_o = r_cnt;
endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Directed bench for sp_ram_arbiter with a small single-port RAM model.
module tb_sp_ram_arbiter;
  localparam int NM = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = 16;

  logic          gclk = 1'b0;
  logic          rst_n = 1'b0;
  logic          err;
  logic [CW-1:0] cnt;
  logic          ram_rvalid = 1'b0;
  logic          inj_rvalid = 1'b0;
  logic [31:0]   ram [16] = '{4: 32'h37, 8: 32'h88, 12: 32'hCC, default: 32'h0};
  int            n_chk = 0;
  int            n_err = 0;

  always #5 gclk = ~gclk;

  sp_ram_arbiter_if #(.NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  sp_ram_arbiter #(.NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk              (gclk),
    .rst_n            (rst_n),
    .bus              (bus),
    .err_o            (err),
    .contention_cnt_o (cnt)
  );

  // RAM: rdata combinational on address, rvalid one cycle after handshake.
  always @(posedge gclk) begin
    ram_rvalid <= bus.mem_req_o & bus.mem_gnt_i;
    if (bus.mem_req_o && bus.mem_gnt_i && bus.mem_we_o)
      ram[bus.mem_addr_o[3:0]] <= bus.mem_wdata_o;
  end
  assign bus.mem_rvalid_i = ram_rvalid | inj_rvalid;
  assign bus.mem_rdata_i  = ram[bus.mem_addr_o[3:0]];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge gclk);
    #1;
  endtask

  initial begin
    bus.m_req_i   = '0;
    bus.m_addr_i  = '0;
    bus.m_we_i    = '0;
    bus.m_wdata_i = '0;
    bus.mem_gnt_i = 1'b1;
    step();

    // reset gating with requests present
    bus.m_req_i = 2'b11;
    @(negedge gclk);
    chk("rst_gnt", bus.m_gnt_o, 2'b00);
    chk("rst_memreq", bus.mem_req_o, 1'b0);
    chk("rst_rvalid", bus.m_rvalid_o, 2'b00);
    chk("rst_err", err, 1'b0);
    chk("rst_cnt", cnt, 16'h0);
    step();
    bus.m_req_i = 2'b00;
    rst_n = 1'b1;

    // single read, master 0
    bus.m_req_i  = 2'b01;
    bus.m_addr_i = {32'h0, 32'h4};
    @(negedge gclk);
    chk("rd_gnt", bus.m_gnt_o, 2'b01);
    chk("rd_addr", bus.mem_addr_o, 32'h4);
    step();
    bus.m_req_i = 2'b00;
    @(negedge gclk);
    chk("rd_rvalid", bus.m_rvalid_o, 2'b01);
    chk("rd_rdata", bus.m_rdata_o, {32'h0, 32'h37});
    step();

    // write then read, master 1
    bus.m_req_i   = 2'b10;
    bus.m_addr_i  = {32'h4, 32'h0};
    bus.m_we_i    = 2'b10;
    bus.m_wdata_i = {32'hDEAD_BEEF, 32'h0};
    @(negedge gclk);
    chk("wr_gnt", bus.m_gnt_o, 2'b10);
    chk("wr_we", bus.mem_we_o, 1'b1);
    chk("wr_wdata", bus.mem_wdata_o, 32'hDEAD_BEEF);
    step();
    bus.m_we_i = 2'b00;
    @(negedge gclk);
    chk("wr2_gnt", bus.m_gnt_o, 2'b10);
    chk("wr2_we", bus.mem_we_o, 1'b0);
    chk("wr_rvalid", bus.m_rvalid_o, 2'b10);
    step();
    bus.m_req_i = 2'b00;
    @(negedge gclk);
    chk("rb_rvalid", bus.m_rvalid_o, 2'b10);
    chk("rb_rdata", bus.m_rdata_o, {32'hDEAD_BEEF, 32'h0});
    step();

    // reset right after a handshake, RAM rvalid still arriving
    bus.m_req_i  = 2'b01;
    bus.m_addr_i = {32'h0, 32'h4};
    step();
    rst_n        = 1'b0;
    bus.m_req_i  = 2'b11;
    bus.m_addr_i = {32'd12, 32'd8};
    @(negedge gclk);
    chk("mid_ramrv", ram_rvalid, 1'b1);
    chk("mid_rvalid", bus.m_rvalid_o, 2'b00);
    step();
    step();
    rst_n = 1'b1;

    // both masters contend for 6 cycles
    for (int k = 0; k < 6; k++) begin
      @(negedge gclk);
      chk("rr_gnt", bus.m_gnt_o, (k % 2) ? 2'b10 : 2'b01);
      chk("rr_rvalid", bus.m_rvalid_o, (k == 0) ? 2'b00 : ((k % 2) ? 2'b01 : 2'b10));
      if (k > 0)
        chk("rr_rdata", bus.m_rdata_o, (k % 2) ? {32'h0, 32'h88} : {32'hCC, 32'h0});
      step();
    end
    bus.m_req_i = 2'b00;
    @(negedge gclk);
    chk("rr_last_rvalid", bus.m_rvalid_o, 2'b10);
    chk("rr_last_rdata", bus.m_rdata_o, {32'hCC, 32'h0});
    chk("rr_cnt", cnt, 16'd6);
    chk("rr_err", err, 1'b0);
    step();

    // stray RAM rvalid three cycles after reset
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    step();
    step();
    @(negedge gclk);
    chk("inj_pre_err", err, 1'b0);
    inj_rvalid = 1'b1;
    @(negedge gclk);
    chk("inj_rvalid", bus.m_rvalid_o, 2'b00);
    step();
    inj_rvalid = 1'b0;
    @(negedge gclk);
    chk("inj_err", err, 1'b1);
    step();
    step();
    step();
    @(negedge gclk);
    chk("inj_sticky", err, 1'b1);
    rst_n = 1'b0;
    step();
    @(negedge gclk);
    chk("inj_clr", err, 1'b0);

    // contention counter saturation, no RAM grant
    bus.m_req_i   = 2'b11;
    bus.mem_gnt_i = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (65534) @(posedge gclk);
    @(negedge gclk);
    chk("sat_fffe", cnt, 16'hFFFE);
    chk("nogrant_gnt", bus.m_gnt_o, 2'b00);
    chk("nogrant_req", bus.mem_req_o, 1'b1);
    @(posedge gclk);
    @(negedge gclk);
    chk("sat_ffff", cnt, 16'hFFFF);
    repeat (4500) @(posedge gclk);
    @(negedge gclk);
    chk("sat_hold", cnt, 16'hFFFF);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/sp_ram_arbiter.md
Name: sp_ram_arbiter

Overview:
Round-robin arbiter that shares the single-port instruction/data RAM between NUM_MASTERS requesters, e.g. the redundant cores of the fault-tolerant system.
- Each master side uses the same req/gnt/rvalid protocol as the RAM port.
- The RAM side connects directly to the sp_ram port signals.
- The arbiter captures read data at grant time, because RAM rdata is combinational on address. It then routes that data with rvalid to the owning master one cycle later.
- It also provides a sticky protocol-error flag and a contention counter for debug.

Parameters:
NUM_MASTERS, 2, number of requesters (2..8)
ADDR_WIDTH, 32, address width per master
DATA_WIDTH, 32, data width per master
CNT_WIDTH, 16, width of contention counter

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
m_req_i  input  NUM_MASTERS  per-master request
m_gnt_o  output  NUM_MASTERS  per-master grant (one-hot or zero)
m_rvalid_o  output  NUM_MASTERS  per-master response valid
m_addr_i  input  NUM_MASTERS*ADDR_WIDTH  packed addresses, master i at [i*ADDR_WIDTH +: ADDR_WIDTH]
m_we_i  input  NUM_MASTERS  per-master write enable
m_wdata_i  input  NUM_MASTERS*DATA_WIDTH  packed write data
m_rdata_o  output  NUM_MASTERS*DATA_WIDTH  packed read data
mem_req_o  output  1  RAM request
mem_gnt_i  input  1  RAM grant
mem_rvalid_i  input  1  RAM response valid
mem_addr_o  output  ADDR_WIDTH  RAM address
mem_we_o  output  1  RAM write enable
mem_wdata_o  output  DATA_WIDTH  RAM write data
mem_rdata_i  input  DATA_WIDTH  RAM read data (combinational on address)
err_o  output  1  sticky: RAM rvalid with no pending response
contention_cnt_o  output  CNT_WIDTH  cycles with two or more simultaneous requests, saturating

Behaviour:
- Reset (rst_n low at posedge clk): rr_ptr=0, resp_pending=0, resp_owner=0, rdata_q=0, err_o=0, contention_cnt_o=0, rst_mask=1.
  - While rst_n is low, mem_req_o=0, m_gnt_o=0 and m_rvalid_o=0 combinationally, regardless of inputs.
- Selection (combinational): sel = first index i with m_req_i[i]=1, searching rr_ptr, rr_ptr+1, ... and wrapping modulo NUM_MASTERS.
  - mem_req_o = |m_req_i.
  - mem_addr_o, mem_we_o, mem_wdata_o are muxed from master sel.
  - When no master requests, these outputs are 0.
- Grant: m_gnt_o[sel] = mem_req_o & mem_gnt_i. All other bits of m_gnt_o are 0. A grant is a handshake.
- On a handshake (registered at posedge):
  - rr_ptr <= (sel+1) mod NUM_MASTERS
  - resp_owner <= sel
  - resp_pending <= 1
  - rdata_q <= mem_rdata_i (old data on writes)
- Without a handshake: resp_pending <= 0 and rr_ptr holds.
- Response:
  - m_rvalid_o[resp_owner] = mem_rvalid_i & resp_pending; all other rvalid bits are 0.
  - m_rdata_o slice resp_owner = rdata_q; all other slices are 0.
  - Latency: handshake in cycle N, rvalid in cycle N+1.
  - Writes also return rvalid; rdata is don't-care to the master.
- Back-to-back: a new handshake in the same cycle as a response is allowed. Throughput is 1 access/cycle; fairness is round-robin over requesting masters only.
- Stable request: a master that is not granted keeps its req, addr, we and wdata stable. The arbiter does not latch requests.
- Error: err_o <= 1 when mem_rvalid_i=1 & resp_pending=0 & rst_mask=0.
  - err_o clears only on reset.
  - rst_mask <= 0 on the first cycle after rst_n goes high. This masks a stale RAM rvalid caused by a handshake issued just before reset.
- Contention: contention_cnt_o increments by 1 in each cycle where popcount(m_req_i) >= 2.
  - It saturates at 2^CNT_WIDTH-1 and does not wrap.
- Reset mid-transaction: the pending response is discarded, no m_rvalid_o is issued for it, and rr_ptr returns to 0.
- Single master requesting: that master is granted every cycle it requests (sel = that master), independent of rr_ptr.

Test Plan:
- Single read, master 0 only (RAM word 4 = 0x0000_0037, addr 4):
  - cycle 0: m_gnt_o=01.
  - cycle 1: m_rvalid_o=01, master 0 rdata=0x37, master 1 rvalid=0.
- Both masters hold req for 6 cycles, mem_gnt_i=1:
  - grants alternate 01,10,01,10,01,10.
  - each rvalid arrives 1 cycle after its grant at the correct owner.
  - contention_cnt_o=6.
- Write then read, master 1: write 0xDEAD_BEEF to addr 4, then read addr 4 on the next cycle:
  - second response rdata=0xDEAD_BEEF.
  - mem_we_o=1 only in the write cycle.
- Apply rst_n low in the cycle after a handshake, while RAM still returns rvalid:
  - no m_rvalid_o is issued and err_o stays 0.
  - rr_ptr=0, so with both masters requesting, master 0 is granted first after reset.
- Inject mem_rvalid_i=1 with no prior handshake, 3 cycles after reset: err_o=1 and stays 1 until the next reset.
- Force 70000 cycles of both masters requesting (CNT_WIDTH=16): contention_cnt_o saturates at 0xFFFF.
